ram_dma_arbiter: RTL and testbench

- Shares the 8 KB main RAM (0x0000-0x1FFF) between the 6502 and a host download port (serial/OSD program loader).
- The host pushes address/data bytes into a small FIFO. Buffered writes drain into RAM only in cycles the CPU cannot use.
- Optionally halts the CPU by gating cpu_clken, so bulk loads run at one byte per clk14.
- Sits between the CPU bus and the RAM port. The top level routes cpu_clken_o, not the raw clock-divider enable, to the CPU.

---
 rtl/apple1_pkg.sv | 14 +
 rtl/dma_fifo.sv | 48 ++++
 rtl/ram_dma_arbiter.sv | 141 ++++++++++++++
 tb/tb_ram_dma_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apple1_pkg.sv
// Shared types and constants for the Apple-1 main RAM / host download path.
package apple1_pkg;

  localparam int         RAM_AW       = 13;
  localparam logic [2:0] RAM_BASE_MSB = 3'b000;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_WAIT = 2'd1,
    HALTED    = 2'd2,
    RESUME    = 2'd3
  } halt_state_t;

endpackage

// File: rtl/dma_fifo.sv
// Registered sync FIFO; a pushed word reaches the head one cycle later.
// Pushes while full and pops while empty are ignored; full/empty come straight from registered pointers.
module dma_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int         PW      = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Extra pointer bit tells full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/ram_dma_arbiter.sv
// Shares main RAM between the 6502 and buffered host writes; DMA uses the slot after each CPU clken, or every cycle while halted.
// Write lands one cycle after the push at the earliest; host_ready drops when the FIFO is full.
module ram_dma_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int RAM_AW     = 13
) (
  input  logic              clk14,
  input  logic              rst_n,
  input  logic              cpu_clken_i,
  output logic              cpu_clken_o,
  input  logic [15:0]       cpu_ab,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_dbo,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_din,
  input  logic              host_valid,
  input  logic [RAM_AW-1:0] host_addr,
  input  logic [7:0]        host_data,
  output logic              host_ready,
  input  logic              host_halt_req,
  output logic              cpu_halted,
  output logic              dma_busy,
  output logic [15:0]       dma_count,
  input  logic              dma_count_clr
);

  import apple1_pkg::*;

  typedef struct packed {
    logic [RAM_AW-1:0] addr;
    logic [7:0]        data;
  } dma_entry_t;

  halt_state_t state_q;
  halt_state_t state_d;
  dma_entry_t  push_ent;
  dma_entry_t  head_ent;
  logic        clken_d;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        grant;
  logic        clken_pass;
  logic        slot_ok;
  logic        halted;
  logic        ram_cs;
  logic [15:0] dma_count_q;

  assign push_ent   = '{addr: host_addr, data: host_data};
  assign host_ready = rst_n & ~fifo_full;
  assign push       = host_valid & host_ready;
  assign grant      = ~fifo_empty & slot_ok;
  assign ram_cs     = (cpu_ab[15:13] == RAM_BASE_MSB);

  dma_fifo #(
    .WIDTH (RAM_AW + 8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk14),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_ent),
    .pop   (grant),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head_ent)
  );

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      clken_d <= 1'b0;
    end else begin
      state_q <= state_d;
      clken_d <= cpu_clken_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:       if (host_halt_req) state_d = HALT_WAIT;
      // The clken that moves us to HALTED still reaches the CPU, so it stops between cycles.
      HALT_WAIT: begin
        if (!host_halt_req)   state_d = RUN;
        else if (cpu_clken_i) state_d = HALTED;
      end
      HALTED:    if (!host_halt_req && fifo_empty) state_d = RESUME;
      RESUME:    state_d = RUN;
      default:   state_d = RUN;
    endcase
  end

  always_comb begin
    clken_pass = 1'b0;
    slot_ok    = 1'b0;
    halted     = 1'b0;
    case (state_q)
      RUN, HALT_WAIT: begin
        clken_pass = 1'b1;
        slot_ok    = clken_d;
      end
      HALTED: begin
        slot_ok = 1'b1;
        halted  = 1'b1;
      end
      // RESUME keeps the CPU address on the port so the next read sees fresh data.
      default: ;
    endcase
  end

  assign cpu_clken_o = rst_n & clken_pass & cpu_clken_i;
  assign cpu_halted  = halted;
  assign dma_busy    = ~fifo_empty;

  always_comb begin
    if (grant) begin
      ram_addr = head_ent.addr;
      ram_din  = head_ent.data;
      ram_we   = 1'b1;
    end else begin
      ram_addr = cpu_ab[RAM_AW-1:0];
      ram_din  = cpu_dbo;
      ram_we   = cpu_we & ram_cs & cpu_clken_o;
    end
  end

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      dma_count_q <= '0;
    end else if (dma_count_clr) begin
      dma_count_q <= grant ? 16'd1 : 16'd0;
    end else if (grant) begin
      dma_count_q <= dma_count_q + 16'd1;
    end
  end

  assign dma_count = dma_count_q;

endmodule

// File: tb/tb_ram_dma_arbiter.sv
// Directed bench: CPU clken every 14 cycles, RAM modelled as a synchronous array fed by the port.
module tb_ram_dma_arbiter;

  logic        clk14 = 1'b0;
  logic        rst_n = 1'b1;
  logic        cpu_clken_i = 1'b0;
  logic        cpu_clken_o;
  logic [15:0] cpu_ab = 16'h1000;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_dbo = 8'h00;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic        host_valid = 1'b0;
  logic [12:0] host_addr = 13'h0000;
  logic [7:0]  host_data = 8'h00;
  logic        host_ready;
  logic        host_halt_req = 1'b0;
  logic        cpu_halted;
  logic        dma_busy;
  logic [15:0] dma_count;
  logic        dma_count_clr = 1'b0;

  int total = 0;
  int bad = 0;
  int gen_cnt = 0;
  int we_cnt = 0;
  logic [7:0] mem [0:8191];
  logic [7:0] rdata;

  ram_dma_arbiter #(.FIFO_DEPTH(4), .RAM_AW(13)) dut (
    .clk14(clk14), .rst_n(rst_n), .cpu_clken_i(cpu_clken_i), .cpu_clken_o(cpu_clken_o),
    .cpu_ab(cpu_ab), .cpu_we(cpu_we), .cpu_dbo(cpu_dbo),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .host_valid(host_valid), .host_addr(host_addr), .host_data(host_data), .host_ready(host_ready),
    .host_halt_req(host_halt_req), .cpu_halted(cpu_halted), .dma_busy(dma_busy),
    .dma_count(dma_count), .dma_count_clr(dma_count_clr)
  );

  always #35 clk14 = ~clk14;

  // Clock-divider model: one-cycle enable every 14 clocks.
  always @(posedge clk14) begin
    #1;
    gen_cnt = (gen_cnt == 13) ? 0 : gen_cnt + 1;
    cpu_clken_i = (gen_cnt == 13);
  end

  always @(posedge clk14) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      we_cnt <= we_cnt + 1;
    end
    rdata <= mem[ram_addr];
  end

  task automatic step();
    @(posedge clk14);
    #5;
  endtask

  task automatic wait_clken();
    int n = 0;
    do begin
      step();
      n++;
    end while (cpu_clken_i !== 1'b1 && n < 40);
    if (cpu_clken_i !== 1'b1) begin
      total++; bad++;
      $display("FAIL clken_wait: no cpu_clken_i pulse within %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    int we_snap;
    rst_n = 1'b0;
    cpu_we = 1'b1; cpu_ab = 16'h0100; cpu_dbo = 8'h55;
    wait_clken();
    #1;
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
    total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL rst_host_ready: got %b want 0", host_ready); end
    total++; if (dma_count !== 16'h0000) begin bad++; $display("FAIL rst_count: got %h want 0000", dma_count); end
    total++; if (cpu_halted !== 1'b0) begin bad++; $display("FAIL rst_halted: got %b want 0", cpu_halted); end
    total++; if (dma_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", dma_busy); end
    cpu_we = 1'b0; cpu_ab = 16'h1000;
    rst_n = 1'b1;
    #1;
    total++; if (host_ready !== 1'b1) begin bad++; $display("FAIL rel_host_ready: got %b want 1", host_ready); end
    step();
    total++; if (cpu_halted !== 1'b0) begin bad++; $display("FAIL rel_halted: got %b want 0", cpu_halted); end
    // Reset with a buffered byte must discard it without writing.
    wait_clken();
    step(); host_valid = 1'b1; host_addr = 13'h1FF0; host_data = 8'hEE;
    step(); host_valid = 1'b0;
    #1;
    total++; if (dma_busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", dma_busy); end
    we_snap = we_cnt;
    rst_n = 1'b0;
    #1;
    total++; if (dma_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", dma_busy); end
    total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready: got %b want 0", host_ready); end
    step(); step();
    rst_n = 1'b1;
    wait_clken(); wait_clken();
    total++; if (we_cnt !== we_snap) begin bad++; $display("FAIL mid_rst_writes: got %0d writes want 0", we_cnt - we_snap); end
    total++; if (dma_count !== 16'h0000) begin bad++; $display("FAIL mid_rst_count: got %h want 0000", dma_count); end
  endtask

  task automatic test_single_load();
    int spurious = 0;
    int n = 0;
    wait_clken();
    step(); host_valid = 1'b1; host_addr = 13'h0300; host_data = 8'hA5;
    step(); host_valid = 1'b0;
    do begin
      #1;
      if (ram_we === 1'b1) spurious++;
      if (cpu_clken_i === 1'b1) break;
      step();
      n++;
    end while (n < 30);
    total++; if (spurious != 0) begin bad++; $display("FAIL single_early_we: got %0d early writes want 0", spurious); end
    step(); #1;
    total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL single_we: got %b want 1", ram_we); end
    total++; if (ram_addr !== 13'h0300) begin bad++; $display("FAIL single_addr: got %h want 0300", ram_addr); end
    total++; if (ram_din !== 8'hA5) begin bad++; $display("FAIL single_din: got %h want a5", ram_din); end
    step();
    total++; if (dma_count !== 16'd1) begin bad++; $display("FAIL single_count: got %0d want 1", dma_count); end
    total++; if (dma_busy !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", dma_busy); end
    cpu_ab = 16'h0300;
    step();
    total++; if (rdata !== 8'hA5) begin bad++; $display("FAIL single_cpu_read: got %h want a5", rdata); end
    cpu_ab = 16'h1000;
  endtask

  task automatic test_back_pressure();
    int pushed = 0;
    int w = 0;
    int last = 0;
    step(); dma_count_clr = 1'b1;
    step(); dma_count_clr = 1'b0;
    wait_clken();
    for (int c = 0; c < 200 && w < 8; c++) begin
      step();
      if (c == 4) begin
        total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full: got %b want 0", host_ready); end
      end
      if (pushed < 8 && host_ready === 1'b1) begin
        host_valid = 1'b1; host_addr = 13'h0400 + 13'(pushed); host_data = 8'h40 + 8'(pushed);
        pushed++;
      end else begin
        host_valid = 1'b0;
      end
      #1;
      if (ram_we === 1'b1) begin
        total++; if (ram_addr !== 13'h0400 + 13'(w)) begin bad++; $display("FAIL bp_order: got %h want %h", ram_addr, 13'h0400 + 13'(w)); end
        if (w > 0) begin
          total++; if (c - last != 14) begin bad++; $display("FAIL bp_rate: got gap %0d want 14", c - last); end
        end
        last = c;
        w++;
      end
    end
    host_valid = 1'b0;
    step();
    total++; if (dma_count !== 16'd8) begin bad++; $display("FAIL bp_count: got %0d want 8", dma_count); end
    total++; if (dma_busy !== 1'b0) begin bad++; $display("FAIL bp_busy: got %b want 0", dma_busy); end
    for (int i = 0; i < 8; i++) begin
      total++; if (mem[13'h0400 + 13'(i)] !== 8'h40 + 8'(i)) begin bad++; $display("FAIL bp_mem%0d: got %h want %h", i, mem[13'h0400 + 13'(i)], 8'h40 + 8'(i)); end
    end
  endtask

  task automatic test_halt_bulk();
    int passes = 0;
    int n = 0;
    int sent = 0;
    int w = 0;
    int first = -1;
    int last = 0;
    int leak = 0;
    step(); dma_count_clr = 1'b1;
    step(); dma_count_clr = 1'b0;
    wait_clken();
    step(); host_halt_req = 1'b1;
    do begin
      #1;
      if (cpu_halted === 1'b1) break;
      if (cpu_clken_o === 1'b1) passes++;
      step();
      n++;
    end while (n < 40);
    total++; if (cpu_halted !== 1'b1) begin bad++; $display("FAIL halt_enter: got %b want 1", cpu_halted); end
    total++; if (passes != 1) begin bad++; $display("FAIL halt_passes: got %0d want 1", passes); end
    for (int c = 0; c < 600 && w < 256; c++) begin
      if (sent < 256 && host_ready === 1'b1) begin
        host_valid = 1'b1; host_addr = 13'h0800 + 13'(sent); host_data = 8'(sent) ^ 8'h5A;
        sent++;
      end else begin
        host_valid = 1'b0;
      end
      #1;
      if (cpu_clken_o === 1'b1) leak++;
      if (ram_we === 1'b1) begin
        total++; if (ram_addr !== 13'h0800 + 13'(w) || ram_din !== (8'(w) ^ 8'h5A)) begin
          bad++; $display("FAIL halt_write%0d: got %h=%h want %h=%h", w, ram_addr, ram_din, 13'h0800 + 13'(w), 8'(w) ^ 8'h5A);
        end
        if (first < 0) first = c;
        last = c;
        w++;
      end
      step();
    end
    host_valid = 1'b0;
    total++; if (last - first != 255) begin bad++; $display("FAIL halt_rate: got span %0d want 255", last - first); end
    total++; if (leak != 0) begin bad++; $display("FAIL halt_clken_leak: got %0d pulses want 0", leak); end
    total++; if (dma_count !== 16'd256) begin bad++; $display("FAIL halt_count: got %0d want 256", dma_count); end
    total++; if (mem[13'h08FF] !== 8'hA5) begin bad++; $display("FAIL halt_mem_last: got %h want a5", mem[13'h08FF]); end
    // Drop the request one cycle before a clken so that pulse falls in RESUME.
    cpu_ab = 16'h0123;
    wait_clken();
    repeat (13) step();
    host_halt_req = 1'b0;
    step(); #1;
    total++; if (cpu_halted !== 1'b0) begin bad++; $display("FAIL resume_halted: got %b want 0", cpu_halted); end
    total++; if (cpu_clken_o !== 1'b0) begin bad++; $display("FAIL resume_clken: got %b want 0", cpu_clken_o); end
    total++; if (ram_addr !== 13'h0123) begin bad++; $display("FAIL resume_addr: got %h want 0123", ram_addr); end
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL resume_we: got %b want 0", ram_we); end
    wait_clken(); #1;
    total++; if (cpu_clken_o !== 1'b1) begin bad++; $display("FAIL resume_run_clken: got %b want 1", cpu_clken_o); end
    cpu_ab = 16'h1000;
  endtask

  task automatic test_collision();
    wait_clken();
    step(); host_valid = 1'b1; host_addr = 13'h0200; host_data = 8'h22;
    step(); host_valid = 1'b0;
    wait_clken();
    cpu_ab = 16'h0200; cpu_we = 1'b1; cpu_dbo = 8'h11;
    #1;
    total++; if (ram_we !== 1'b1 || ram_din !== 8'h11) begin bad++; $display("FAIL coll_cpu: got we=%b din=%h want 1/11", ram_we, ram_din); end
    step();
    cpu_we = 1'b0; cpu_ab = 16'h1000;
    #1;
    total++; if (ram_we !== 1'b1 || ram_addr !== 13'h0200 || ram_din !== 8'h22) begin
      bad++; $display("FAIL coll_dma: got we=%b %h=%h want 1 0200=22", ram_we, ram_addr, ram_din);
    end
    step();
    total++; if (mem[13'h0200] !== 8'h22) begin bad++; $display("FAIL coll_final: got %h want 22", mem[13'h0200]); end
  endtask

  task automatic test_counter();
    step(); dma_count_clr = 1'b1;
    step(); dma_count_clr = 1'b0;
    total++; if (dma_count !== 16'h0000) begin bad++; $display("FAIL cnt_clr: got %h want 0000", dma_count); end
    force dut.dma_count_q = 16'hFFFF;
    #1;
    release dut.dma_count_q;
    step();
    total++; if (dma_count !== 16'hFFFF) begin bad++; $display("FAIL cnt_preload: got %h want ffff", dma_count); end
    wait_clken();
    step(); host_valid = 1'b1; host_addr = 13'h0310; host_data = 8'h77;
    step(); host_valid = 1'b0;
    wait_clken();
    step();
    step();
    total++; if (dma_count !== 16'h0000) begin bad++; $display("FAIL cnt_wrap: got %h want 0000", dma_count); end
    total++; if (mem[13'h0310] !== 8'h77) begin bad++; $display("FAIL cnt_wrap_mem: got %h want 77", mem[13'h0310]); end
    wait_clken();
    step(); host_valid = 1'b1; host_addr = 13'h0311; host_data = 8'h78;
    step(); host_valid = 1'b0;
    wait_clken();
    step();
    dma_count_clr = 1'b1;
    #1;
    total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL cnt_clr_grant_we: got %b want 1", ram_we); end
    step();
    dma_count_clr = 1'b0;
    total++; if (dma_count !== 16'h0001) begin bad++; $display("FAIL cnt_clr_grant: got %h want 0001", dma_count); end
  endtask

  initial begin
    #2;
    test_reset();
    test_single_load();
    test_back_pressure();
    test_halt_bulk();
    test_collision();
    test_counter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
